// File: rtl/wb2axi.sv
// wb2axi: Wishbone classic slave to single-beat 32-bit AXI4 master bridge; ports: i_clk, i_rst_n (sync active-low), Wishbone i_wb_*/o_wb_*, AXI aw/w/b/ar/r channels; define WB2AXI_ERR_EN to turn SLVERR/DECERR into o_wb_err
module wb2axi #(
  parameter int AW = 16,
  parameter int IW = 5,
  parameter int AXI_ID = 0
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [AW-1:2] i_wb_adr,
  input  logic [31:0]   i_wb_dat,
  input  logic [3:0]    i_wb_sel,
  input  logic          i_wb_we,
  input  logic          i_wb_cyc,
  input  logic          i_wb_stb,
  output logic [31:0]   o_wb_rdt,
  output logic          o_wb_ack,
  output logic          o_wb_err,
  output logic [AW-1:0] o_awaddr,
  output logic [IW-1:0] o_awid,
  output logic          o_awvalid,
  input  logic          i_awready,
  output logic [31:0]   o_wdata,
  output logic [3:0]    o_wstrb,
  output logic          o_wlast,
  output logic          o_wvalid,
  input  logic          i_wready,
  input  logic [IW-1:0] i_bid,
  input  logic [1:0]    i_bresp,
  input  logic          i_bvalid,
  output logic          o_bready,
  output logic [AW-1:0] o_araddr,
  output logic [IW-1:0] o_arid,
  output logic          o_arvalid,
  input  logic          i_arready,
  input  logic [31:0]   i_rdata,
  input  logic [IW-1:0] i_rid,
  input  logic [1:0]    i_rresp,
  input  logic          i_rlast,
  input  logic          i_rvalid,
  output logic          o_rready
);
  typedef enum logic [2:0] {IDLE, WRITE, WRESP, READ, RDATA, ACK} state_t;
  state_t state;
  logic [AW-1:2] adr;
  logic abort, bad_b, bad_r, fin, unused;
`ifdef WB2AXI_ERR_EN
  assign bad_b = i_bresp[1];
  assign bad_r = i_rresp[1];
`else
  assign bad_b = 1'b0;
  assign bad_r = 1'b0;
`endif
  assign unused = ^{i_bid, i_rid, i_rlast, i_bresp, i_rresp};
  assign o_awaddr = {adr, 2'b00};
  assign o_araddr = {adr, 2'b00};
  assign o_awid = IW'(AXI_ID);
  assign o_arid = IW'(AXI_ID);
  assign o_wlast = 1'b1;
  // the response is only reported while the master still owns the cycle
  assign fin = i_wb_cyc && !abort;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= IDLE;
      adr <= '0;
      o_wdata <= '0;
      o_wstrb <= '0;
      o_awvalid <= 1'b0;
      o_wvalid <= 1'b0;
      o_bready <= 1'b0;
      o_arvalid <= 1'b0;
      o_rready <= 1'b0;
      o_wb_ack <= 1'b0;
      o_wb_err <= 1'b0;
      o_wb_rdt <= '0;
      abort <= 1'b0;
    end else begin
      if (state != IDLE && state != ACK && !i_wb_cyc) abort <= 1'b1;
      case (state)
        IDLE: if (i_wb_cyc && i_wb_stb) begin
          adr <= i_wb_adr;
          o_wdata <= i_wb_dat;
          o_wstrb <= i_wb_sel;
          o_awvalid <= i_wb_we;
          o_wvalid <= i_wb_we;
          o_arvalid <= !i_wb_we;
          state <= i_wb_we ? WRITE : READ;
        end
        WRITE: begin
          if (i_awready) o_awvalid <= 1'b0;
          if (i_wready) o_wvalid <= 1'b0;
          // address and data channels retire independently; wait for both
          if ((!o_awvalid || i_awready) && (!o_wvalid || i_wready)) begin
            o_bready <= 1'b1;
            state <= WRESP;
          end
        end
        WRESP: if (i_bvalid) begin
          o_bready <= 1'b0;
          o_wb_ack <= fin && !bad_b;
          o_wb_err <= fin && bad_b;
          state <= ACK;
        end
        READ: if (i_arready) begin
          o_arvalid <= 1'b0;
          o_rready <= 1'b1;
          state <= RDATA;
        end
        RDATA: if (i_rvalid) begin
          o_wb_rdt <= i_rdata;
          o_rready <= 1'b0;
          o_wb_ack <= fin && !bad_r;
          o_wb_err <= fin && bad_r;
          state <= ACK;
        end
        ACK: begin
          o_wb_ack <= 1'b0;
          o_wb_err <= 1'b0;
          abort <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wb2axi.sv
// tb_wb2axi: randomized self-checking bench for wb2axi against a memory/latency reference model
module tb_wb2axi;
  localparam int AW = 16;
  localparam int IW = 5;
  localparam int ID = 3;
`ifdef WB2AXI_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  logic clk, rst_n;
  logic [AW-1:2] wb_adr;
  logic [31:0] wb_dat, wb_rdt, wdata, rdata;
  logic [3:0] wb_sel, wstrb;
  logic wb_we, wb_cyc, wb_stb, wb_ack, wb_err;
  logic [AW-1:0] awaddr, araddr;
  logic [IW-1:0] awid, arid, bid, rid;
  logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rlast, rvalid, rready;
  logic [1:0] bresp, rresp;

  wb2axi #(.AW(AW), .IW(IW), .AXI_ID(ID)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_wb_adr(wb_adr), .i_wb_dat(wb_dat), .i_wb_sel(wb_sel), .i_wb_we(wb_we),
    .i_wb_cyc(wb_cyc), .i_wb_stb(wb_stb), .o_wb_rdt(wb_rdt), .o_wb_ack(wb_ack), .o_wb_err(wb_err),
    .o_awaddr(awaddr), .o_awid(awid), .o_awvalid(awvalid), .i_awready(awready),
    .o_wdata(wdata), .o_wstrb(wstrb), .o_wlast(wlast), .o_wvalid(wvalid), .i_wready(wready),
    .i_bid(bid), .i_bresp(bresp), .i_bvalid(bvalid), .o_bready(bready),
    .o_araddr(araddr), .o_arid(arid), .o_arvalid(arvalid), .i_arready(arready),
    .i_rdata(rdata), .i_rid(rid), .i_rresp(rresp), .i_rlast(rlast), .i_rvalid(rvalid), .o_rready(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] slave_mem [0:15];
  logic [31:0] model_mem [0:15];
  logic [31:0] last_rd;

  int ack_cnt, err_cnt, ack_cyc, aw_cycles, w_cycles, ar_cycles, bready_first, aw_n, w_n, viol;
  bit timeout, b_hs, r_hs;
  logic [AW-1:0] cap_awaddr, cap_araddr;
  logic [31:0] cap_wdata, cap_rdt;
  logic [3:0] cap_wstrb;
  logic [IW-1:0] cap_awid, cap_arid;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // One Wishbone request plus an AXI slave with per-channel ready/valid delays.
  // Cycle k is the cycle after the k-th rising edge following the strobe; observations at negedge.
  task automatic run(input bit we, input logic [AW-1:2] adr, input logic [31:0] dat, input logic [3:0] sel,
                     input int aw_d, input int w_d, input int b_d, input int ar_d, input int r_d,
                     input logic [1:0] resp, input int abort_at);
    int aw_c, w_c, b_c, ar_c, r_c, k, done_at;
    bit aw_hs, w_hs, ar_hs, pa, pw, par;
    aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0; k = 0; done_at = -1;
    aw_hs = 0; w_hs = 0; ar_hs = 0; pa = 0; pw = 0; par = 0;
    b_hs = 0; r_hs = 0; timeout = 0;
    ack_cnt = 0; err_cnt = 0; ack_cyc = -1; aw_cycles = 0; w_cycles = 0; ar_cycles = 0;
    bready_first = -1; aw_n = 0; w_n = 0; viol = 0;
    cap_awaddr = 'x; cap_araddr = 'x; cap_wdata = 'x; cap_wstrb = 'x; cap_rdt = 'x;
    bresp = resp; rresp = resp;
    wb_cyc = 1; wb_stb = 1; wb_we = we; wb_adr = adr; wb_dat = dat; wb_sel = sel;
    while (1) begin
      @(negedge clk);
      k++;
      if (wb_ack || wb_err) begin
        ack_cyc = k;
        cap_rdt = wb_rdt;
        if (!wb_cyc) viol++;
      end
      if (wb_ack) ack_cnt++;
      if (wb_err) err_cnt++;
      if ((pa && !awvalid) || (pw && !wvalid) || (par && !arvalid)) viol++;
      if (bready && (awvalid || wvalid)) viol++;
      if (awvalid) aw_cycles++;
      if (wvalid) w_cycles++;
      if (arvalid) ar_cycles++;
      if (bready && bready_first < 0) bready_first = k;
      if (wb_ack || wb_err || k == abort_at) begin
        wb_cyc = 0; wb_stb = 0;
      end
      bvalid = aw_hs && w_hs && !b_hs && b_c >= b_d;
      if (aw_hs && w_hs && !b_hs) b_c++;
      if (bvalid && bready) b_hs = 1;
      rvalid = ar_hs && !r_hs && r_c >= r_d;
      rdata = rvalid ? slave_mem[araddr[5:2]] : $urandom;
      if (ar_hs && !r_hs) r_c++;
      if (rvalid && rready) r_hs = 1;
      awready = awvalid && aw_c >= aw_d;
      if (awvalid) aw_c++;
      if (awready) begin
        aw_hs = 1; aw_n++; cap_awaddr = awaddr; cap_awid = awid;
      end
      wready = wvalid && w_c >= w_d;
      if (wvalid) w_c++;
      if (wready) begin
        w_hs = 1; w_n++; cap_wdata = wdata; cap_wstrb = wstrb;
        slave_mem[awaddr[5:2]] = merge(slave_mem[awaddr[5:2]], wdata, wstrb);
      end
      arready = arvalid && ar_c >= ar_d;
      if (arvalid) ar_c++;
      if (arready) begin
        ar_hs = 1; cap_araddr = araddr; cap_arid = arid;
      end
      pa = awvalid && !awready;
      pw = wvalid && !wready;
      par = arvalid && !arready;
      bid = IW'($urandom); rid = IW'($urandom);
      if (done_at < 0 && (b_hs || r_hs)) done_at = k;
      if (done_at >= 0 && k >= done_at + 2) break;
      if (k >= 60) begin
        timeout = 1;
        break;
      end
    end
    wb_cyc = 0; wb_stb = 0;
    awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({wb_ack, wb_err, awvalid, wvalid, bready, arvalid, rready} !== 7'b0) begin
      errors++; $display("FAIL reset_ctrl got %b exp 0", {wb_ack, wb_err, awvalid, wvalid, bready, arvalid, rready});
    end
    checks++;
    if ({wb_rdt, wdata, wstrb, awaddr, araddr} !== '0) begin
      errors++; $display("FAIL reset_data got rdt %h wdata %h wstrb %h awaddr %h exp 0", wb_rdt, wdata, wstrb, awaddr);
    end
    checks++;
    if ({awid, arid, wlast} !== {IW'(ID), IW'(ID), 1'b1}) begin
      errors++; $display("FAIL const_out got awid %0d arid %0d wlast %b exp %0d %0d 1", awid, arid, wlast, ID, ID);
    end
    rst_n = 1;
    @(negedge clk);
    checks++;
    if ({wb_ack, awvalid, arvalid} !== 3'b0) begin
      errors++; $display("FAIL idle_after_reset got %b exp 000", {wb_ack, awvalid, arvalid});
    end
    last_rd = 0;
  endtask

  task automatic test_write_basic();
    logic [AW-1:2] a;
    a = 14'(16'h1234 >> 2);
    run(1, a, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 2'b00, -1);
    model_mem[a[5:2]] = merge(model_mem[a[5:2]], 32'hDEADBEEF, 4'hF);
    checks++;
    if ({cap_awaddr, cap_wdata, cap_wstrb} !== {16'h1234, 32'hDEADBEEF, 4'hF}) begin
      errors++; $display("FAIL wr_basic_fields got %h %h %h exp 1234 deadbeef f", cap_awaddr, cap_wdata, cap_wstrb);
    end
    checks++;
    if ({aw_cycles, w_cycles, bready_first, ack_cyc} !== {32'd1, 32'd1, 32'd2, 32'd3}) begin
      errors++; $display("FAIL wr_basic_timing got aw %0d w %0d bready@%0d ack@%0d exp 1 1 2 3", aw_cycles, w_cycles, bready_first, ack_cyc);
    end
    checks++;
    if ({ack_cnt, err_cnt, viol, 32'(timeout)} !== {32'd1, 32'd0, 32'd0, 32'd0}) begin
      errors++; $display("FAIL wr_basic_ack got ack %0d err %0d viol %0d to %0d exp 1 0 0 0", ack_cnt, err_cnt, viol, timeout);
    end
    checks++;
    if (wb_rdt !== last_rd) begin
      errors++; $display("FAIL wr_keeps_rdt got %h exp %h", wb_rdt, last_rd);
    end
  endtask

  task automatic test_write_aw_delay();
    run(1, 14'h0003, 32'h0BADF00D, 4'h5, 4, 0, 0, 0, 0, 2'b00, -1);
    model_mem[3] = merge(model_mem[3], 32'h0BADF00D, 4'h5);
    checks++;
    if ({aw_cycles, w_cycles, bready_first, ack_cyc, ack_cnt} !== {32'd5, 32'd1, 32'd6, 32'd7, 32'd1}) begin
      errors++; $display("FAIL wr_awdelay got aw %0d w %0d bready@%0d ack@%0d n %0d exp 5 1 6 7 1", aw_cycles, w_cycles, bready_first, ack_cyc, ack_cnt);
    end
    checks++;
    if (viol !== 0) begin
      errors++; $display("FAIL wr_awdelay_proto got %0d violations exp 0", viol);
    end
  endtask

  task automatic test_read_basic();
    slave_mem[0] = 32'hA5A50001;
    model_mem[0] = 32'hA5A50001;
    run(0, 14'(16'h0040 >> 2), 32'h0, 4'h0, 0, 0, 0, 0, 1, 2'b00, -1);
    last_rd = 32'hA5A50001;
    checks++;
    if ({cap_rdt, ack_cyc, ack_cnt, err_cnt} !== {32'hA5A50001, 32'd4, 32'd1, 32'd0}) begin
      errors++; $display("FAIL rd_basic got rdt %h ack@%0d n %0d err %0d exp a5a50001 4 1 0", cap_rdt, ack_cyc, ack_cnt, err_cnt);
    end
    checks++;
    if ({cap_araddr, cap_arid, ar_cycles} !== {16'h0040, IW'(ID), 32'd1}) begin
      errors++; $display("FAIL rd_basic_addr got %h id %0d ar %0d exp 0040 %0d 1", cap_araddr, cap_arid, ar_cycles, ID);
    end
    checks++;
    if (wb_rdt !== 32'hA5A50001) begin
      errors++; $display("FAIL rd_hold got %h exp a5a50001", wb_rdt);
    end
  endtask

  task automatic test_read_err();
    slave_mem[9] = 32'h5EED0009;
    model_mem[9] = 32'h5EED0009;
    run(0, 14'h0009, 32'h0, 4'h0, 0, 0, 0, 1, 0, 2'b10, -1);
    last_rd = 32'h5EED0009;
    checks++;
    if ({ack_cnt, err_cnt} !== {32'(!ERR_EN), 32'(ERR_EN)}) begin
      errors++; $display("FAIL rd_err got ack %0d err %0d exp %0d %0d", ack_cnt, err_cnt, !ERR_EN, ERR_EN);
    end
    checks++;
    if ({cap_rdt, ack_cyc} !== {32'h5EED0009, 32'd4}) begin
      errors++; $display("FAIL rd_err_data got %h @%0d exp 5eed0009 @4", cap_rdt, ack_cyc);
    end
  endtask

  task automatic test_abort();
    run(1, 14'h0006, 32'h11223344, 4'hF, 2, 1, 1, 0, 0, 2'b00, 1);
    model_mem[6] = merge(model_mem[6], 32'h11223344, 4'hF);
    checks++;
    if ({ack_cnt, err_cnt, 32'(b_hs), aw_n, w_n} !== {32'd0, 32'd0, 32'd1, 32'd1, 32'd1}) begin
      errors++; $display("FAIL abort got ack %0d err %0d bhs %0d aw %0d w %0d exp 0 0 1 1 1", ack_cnt, err_cnt, b_hs, aw_n, w_n);
    end
    checks++;
    if ({viol, 32'(timeout)} !== 64'd0) begin
      errors++; $display("FAIL abort_proto got viol %0d to %0d exp 0 0", viol, timeout);
    end
    run(0, 14'h0006, 32'h0, 4'h0, 0, 0, 0, 1, 1, 2'b00, -1);
    last_rd = model_mem[6];
    checks++;
    if ({cap_rdt, ack_cyc, ack_cnt} !== {model_mem[6], 32'd5, 32'd1}) begin
      errors++; $display("FAIL after_abort_rd got %h @%0d n %0d exp %h @5 1", cap_rdt, ack_cyc, ack_cnt, model_mem[6]);
    end
  endtask

  task automatic test_reset_mid_read();
    int hits;
    wb_cyc = 1; wb_stb = 1; wb_we = 0; wb_adr = 14'h0005;
    @(negedge clk);
    arready = 1;
    @(negedge clk);
    arready = 0;
    checks++;
    if (rready !== 1'b1) begin
      errors++; $display("FAIL rst_mid_setup got rready %b exp 1", rready);
    end
    rst_n = 0;
    @(negedge clk);
    checks++;
    if ({wb_ack, wb_err, awvalid, wvalid, bready, arvalid, rready, wb_rdt, awaddr} !== '0) begin
      errors++; $display("FAIL rst_mid_outs got ctl %b rdt %h addr %h exp 0", {wb_ack, wb_err, awvalid, wvalid, bready, arvalid, rready}, wb_rdt, awaddr);
    end
    rst_n = 1; wb_cyc = 0; wb_stb = 0;
    rvalid = 1; rdata = 32'h12345678; rresp = 2'b00;
    hits = 0;
    repeat (3) begin
      @(negedge clk);
      if (wb_ack || wb_err || wb_rdt != 0 || rready) hits++;
    end
    rvalid = 0;
    checks++;
    if (hits !== 0) begin
      errors++; $display("FAIL rst_stale_rvalid got %0d reactions exp 0", hits);
    end
    last_rd = 0;
    run(0, 14'h0007, 32'h0, 4'h0, 0, 0, 0, 1, 2, 2'b00, -1);
    last_rd = model_mem[7];
    checks++;
    if ({cap_rdt, ack_cyc, ack_cnt} !== {model_mem[7], 32'd6, 32'd1}) begin
      errors++; $display("FAIL rst_then_rd got %h @%0d n %0d exp %h @6 1", cap_rdt, ack_cyc, ack_cnt, model_mem[7]);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      bit we, exp_err;
      logic [AW-1:2] a;
      logic [31:0] d;
      logic [3:0] s;
      logic [1:0] rsp;
      int ad, wd, bd, rd, dd, exp_cyc;
      we = 1'($urandom);
      a = 14'($urandom);
      d = $urandom;
      s = 4'($urandom);
      rsp = 2'($urandom);
      ad = $urandom_range(0, 3); wd = $urandom_range(0, 3); bd = $urandom_range(0, 3);
      rd = $urandom_range(0, 3); dd = $urandom_range(0, 3);
      exp_err = ERR_EN && rsp[1];
      exp_cyc = we ? ((ad > wd ? ad : wd) + bd + 3) : (rd + dd + 3);
      run(we, a, d, s, ad, wd, bd, rd, dd, rsp, -1);
      checks++;
      if ({ack_cnt, err_cnt, ack_cyc, viol, 32'(timeout)} !== {32'(!exp_err), 32'(exp_err), exp_cyc, 32'd0, 32'd0}) begin
        errors++; $display("FAIL rnd%0d_hs got ack %0d err %0d @%0d viol %0d to %0d exp %0d %0d @%0d 0 0", n, ack_cnt, err_cnt, ack_cyc, viol, timeout, !exp_err, exp_err, exp_cyc);
      end
      if (we) begin
        model_mem[a[5:2]] = merge(model_mem[a[5:2]], d, s);
        checks++;
        if ({cap_awaddr, cap_wdata, cap_wstrb, aw_n, w_n} !== {{a, 2'b00}, d, s, 32'd1, 32'd1}) begin
          errors++; $display("FAIL rnd%0d_wr got %h %h %h n %0d %0d exp %h %h %h 1 1", n, cap_awaddr, cap_wdata, cap_wstrb, aw_n, w_n, {a, 2'b00}, d, s);
        end
        checks++;
        if (wb_rdt !== last_rd) begin
          errors++; $display("FAIL rnd%0d_rdt_hold got %h exp %h", n, wb_rdt, last_rd);
        end
      end else begin
        last_rd = model_mem[a[5:2]];
        checks++;
        if ({cap_araddr, cap_rdt} !== {{a, 2'b00}, model_mem[a[5:2]]}) begin
          errors++; $display("FAIL rnd%0d_rd got %h %h exp %h %h", n, cap_araddr, cap_rdt, {a, 2'b00}, model_mem[a[5:2]]);
        end
      end
    end
  endtask

  initial begin
    rst_n = 0; wb_cyc = 0; wb_stb = 0; wb_we = 0; wb_adr = '0; wb_dat = '0; wb_sel = '0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0; bid = 0;
    arready = 0; rvalid = 0; rdata = 0; rresp = 0; rid = 0; rlast = 1;
    for (int i = 0; i < 16; i++) begin
      slave_mem[i] = 0;
      model_mem[i] = 0;
    end
    last_rd = 0;
    test_reset();
    test_write_basic();
    test_write_aw_delay();
    test_read_basic();
    test_read_err();
    test_abort();
    test_reset_mid_read();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no completion exp finish");
    $fatal(1, "watchdog");
  end
endmodule
